// File: rtl/mem_bus_mux_if.sv
// mem_bus_mux_if: CPU-side request/response and target-side fan-out bundle for mem_bus_mux.
// Parameter:
//   NUM_TARGETS  number of target ports
// Signals:
//   cpu_valid/cpu_addr/cpu_wdata/cpu_wstrb/force_trap  request from the CPU
//   cpu_rdata/cpu_ready                                 registered response to the CPU
//   tgt_cs/tgt_we/tgt_addr/tgt_wdata                    fan-out to the targets
//   tgt_rdata/tgt_ready                                 per-target response (flat, 32 bits per target)
//   decode_err/timeout_err                              one-cycle error pulses
// Modports:
//   slave   the interconnect's view
//   master  the CPU/target environment's view
interface mem_bus_mux_if #(
    parameter int NUM_TARGETS = 8
);
    logic                      cpu_valid;
    logic [31:0]               cpu_addr;
    logic [31:0]               cpu_wdata;
    logic [3:0]                cpu_wstrb;
    logic [31:0]               cpu_rdata;
    logic                      cpu_ready;
    logic                      force_trap;
    logic [NUM_TARGETS-1:0]    tgt_cs;
    logic [3:0]                tgt_we;
    logic [31:0]               tgt_addr;
    logic [31:0]               tgt_wdata;
    logic [NUM_TARGETS*32-1:0] tgt_rdata;
    logic [NUM_TARGETS-1:0]    tgt_ready;
    logic                      decode_err;
    logic                      timeout_err;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap, tgt_rdata, tgt_ready,
        output cpu_rdata, cpu_ready, tgt_cs, tgt_we, tgt_addr, tgt_wdata, decode_err, timeout_err
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, force_trap, tgt_rdata, tgt_ready,
        input  cpu_rdata, cpu_ready, tgt_cs, tgt_we, tgt_addr, tgt_wdata, decode_err, timeout_err
    );
endinterface

// File: rtl/mem_bus_mux.sv
// mem_bus_mux: one native memory master fanned out to NUM_TARGETS address-windowed targets,
// with registered response, wait-state timeout, decode-error pulse and trap override.
// Optional feature macro: MEM_BUS_MUX_PROT_EN (adds port fw_app_mode and parameter
// TGT_FW_ONLY; in application mode, firmware-only targets look unmapped).
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   bus          mem_bus_mux_if.slave (cpu_* request/response, tgt_* fan-out, error pulses)
//   fw_app_mode  application-mode flag (MEM_BUS_MUX_PROT_EN only)
module mem_bus_mux #(
    parameter int                          NUM_TARGETS = 8,
    parameter logic [NUM_TARGETS*32-1:0]   TGT_BASE    = {NUM_TARGETS{32'h0}},
    parameter logic [NUM_TARGETS*32-1:0]   TGT_MASK    = {NUM_TARGETS{32'hffffffff}},
    parameter int                          TIMEOUT     = 255,
    parameter logic [31:0]                 ERR_DATA    = 32'hdeadbeef,
    parameter logic [31:0]                 TRAP_DATA   = 32'h0
`ifdef MEM_BUS_MUX_PROT_EN
    ,
    parameter logic [NUM_TARGETS-1:0]      TGT_FW_ONLY = '0
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
`ifdef MEM_BUS_MUX_PROT_EN
    input  logic           fw_app_mode,
`endif
    mem_bus_mux_if.slave   bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [31:0]   r_rdata, w_rdata_nx;
    logic          r_ready, r_derr, r_terr, w_derr_nx, w_terr_nx;
    logic          w_hit, w_map, w_sel_ready;
    logic [IW-1:0] w_idx;
    logic [31:0]   w_cap;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--)
            if ((bus.cpu_addr & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
    end

`ifdef MEM_BUS_MUX_PROT_EN
    assign w_map = w_hit && !(fw_app_mode && TGT_FW_ONLY[w_idx]);
`else
    assign w_map = w_hit;
`endif

    assign w_sel_ready = bus.tgt_ready[w_idx];
    // Writes complete with zero read data rather than whatever the target drives.
    assign w_cap       = (|bus.cpu_wstrb) ? 32'h0 : bus.tgt_rdata[w_idx*32 +: 32];

    // Gated by reset_n so the select drops immediately on reset assertion.
    assign bus.tgt_cs      = (reset_n && bus.cpu_valid && w_map && !bus.force_trap && r_state != S_RESP)
                             ? NUM_TARGETS'(1) << w_idx : '0;
    assign bus.tgt_we      = bus.cpu_wstrb;
    assign bus.tgt_addr    = bus.cpu_addr;
    assign bus.tgt_wdata   = bus.cpu_wdata;
    assign bus.cpu_rdata   = r_rdata;
    assign bus.cpu_ready   = r_ready;
    assign bus.decode_err  = r_derr;
    assign bus.timeout_err = r_terr;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rdata_nx = r_rdata;
        w_derr_nx  = 1'b0;
        w_terr_nx  = 1'b0;
        case (r_state)
            S_IDLE: if (bus.cpu_valid) begin
                if (bus.force_trap) begin
                    w_rdata_nx = TRAP_DATA;
                    w_state_nx = S_RESP;
                end else if (!w_map) begin
                    w_rdata_nx = '0;
                    w_derr_nx  = 1'b1;
                    w_state_nx = S_RESP;
                end else if (w_sel_ready) begin
                    w_rdata_nx = w_cap;
                    w_state_nx = S_RESP;
                end else begin
                    w_cnt_nx   = CW'(1);
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: if (!bus.cpu_valid) begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end else if (w_sel_ready) begin
                w_rdata_nx = w_cap;
                w_cnt_nx   = '0;
                w_state_nx = S_RESP;
            end else if (TIMEOUT != 0 && r_cnt == CW'(TIMEOUT)) begin
                w_rdata_nx = ERR_DATA;
                w_terr_nx  = 1'b1;
                w_cnt_nx   = '0;
                w_state_nx = S_RESP;
            end else if (r_cnt != '1) begin
                w_cnt_nx   = r_cnt + CW'(1);
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_derr  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rdata <= w_rdata_nx;
            r_ready <= (w_state_nx == S_RESP);
            r_derr  <= w_derr_nx;
            r_terr  <= w_terr_nx;
        end
    end
endmodule

// File: tb/tb_mem_bus_mux.sv
// tb_mem_bus_mux: directed checks of mem_bus_mux (decode, wait states, timeout, unmapped, trap, reset).
module tb_mem_bus_mux;
    localparam int NT = 4;
    localparam logic [NT*32-1:0] BASE  = {32'hc000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    localparam logic [NT*32-1:0] MASK  = {32'hc000_0000, 32'hc000_0000, 32'hf000_0000, 32'hc000_0000};
    localparam logic [NT*32-1:0] TDATA = {32'hc3c3_3333, 32'h1234_5678, 32'hb1b1_1111, 32'ha0a0_0000};
    localparam logic [31:0] TRAP = 32'h7ea9_0001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic ftrap = 1'b0;
    int lat = 0;
    int tcnt = 0;
    bit sel_b = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [NT-1:0] rdy;
    logic [NT-1:0] cs_x;
    logic rdy_x, de_x, te_x;
    logic [31:0] rd_x;
`ifdef MEM_BUS_MUX_PROT_EN
    logic fw = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_bus_mux_if #(.NUM_TARGETS(NT)) bi_a ();
    mem_bus_mux_if #(.NUM_TARGETS(NT)) bi_b ();

    assign bi_a.cpu_valid = valid;
    assign bi_a.cpu_addr = a;
    assign bi_a.cpu_wdata = wdata;
    assign bi_a.cpu_wstrb = wstrb;
    assign bi_a.force_trap = ftrap;
    assign bi_a.tgt_rdata = TDATA;
    assign bi_a.tgt_ready = rdy;
    assign bi_b.cpu_valid = valid;
    assign bi_b.cpu_addr = a;
    assign bi_b.cpu_wdata = wdata;
    assign bi_b.cpu_wstrb = wstrb;
    assign bi_b.force_trap = ftrap;
    assign bi_b.tgt_rdata = TDATA;
    assign bi_b.tgt_ready = rdy;

    // Target model: the selected target becomes ready once it has seen `lat` select cycles.
    always @(posedge clk) tcnt <= (|bi_a.tgt_cs) ? tcnt + 1 : 0;
    assign rdy = bi_a.tgt_cs & {NT{tcnt >= lat}};

    assign cs_x  = sel_b ? bi_b.tgt_cs : bi_a.tgt_cs;
    assign rdy_x = sel_b ? bi_b.cpu_ready : bi_a.cpu_ready;
    assign de_x  = sel_b ? bi_b.decode_err : bi_a.decode_err;
    assign te_x  = sel_b ? bi_b.timeout_err : bi_a.timeout_err;
    assign rd_x  = sel_b ? bi_b.cpu_rdata : bi_a.cpu_rdata;

    mem_bus_mux #(
        .NUM_TARGETS(NT), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT(255), .TRAP_DATA(TRAP)
`ifdef MEM_BUS_MUX_PROT_EN
        , .TGT_FW_ONLY(4'b0001)
`endif
    ) u_dut_a (
        .clk(clk),
        .reset_n(reset_n),
`ifdef MEM_BUS_MUX_PROT_EN
        .fw_app_mode(fw),
`endif
        .bus(bi_a)
    );

    mem_bus_mux #(
        .NUM_TARGETS(NT), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT(4), .TRAP_DATA(TRAP)
    ) u_dut_b (
        .clk(clk),
        .reset_n(reset_n),
`ifdef MEM_BUS_MUX_PROT_EN
        .fw_app_mode(1'b0),
`endif
        .bus(bi_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU access from posedge+1; counts select cycles, latency to cpu_ready and response fields.
    task automatic xact(input string tag, input logic [31:0] addr, input logic [3:0] ws, input logic trap,
                        input int l, input bit use_b, input int e_cyc, input logic [NT-1:0] e_cs,
                        input int e_lat, input logic [31:0] e_rd, input logic e_de, input logic e_te);
        int cyc = 0;
        int lo = 0;
        logic [NT-1:0] cs_or = '0;
        logic [31:0] rd = '0;
        logic de = 1'b0;
        logic te = 1'b0;
        logic tail;
        sel_b = use_b;
        lat = l;
        a = addr;
        wstrb = ws;
        ftrap = trap;
        valid = 1'b1;
        for (int n = 1; n <= 40 && lo == 0; n++) begin
            @(negedge clk);
            if (|cs_x) begin
                cyc++;
                cs_or |= cs_x;
            end
            @(posedge clk);
            #1;
            if (rdy_x) begin
                lo = n;
                rd = rd_x;
                de = de_x;
                te = te_x;
            end
        end
        valid = 1'b0;
        wstrb = '0;
        ftrap = 1'b0;
        @(posedge clk);
        #1;
        tail = rdy_x | de_x | te_x;
        @(posedge clk);
        #1;
        check({tag, " cs_cycles"}, cyc, e_cyc);
        check({tag, " cs"}, 32'(cs_or), 32'(e_cs));
        check({tag, " latency"}, lo, e_lat);
        check({tag, " rdata"}, rd, e_rd);
        check({tag, " decode_err"}, 32'(de), 32'(e_de));
        check({tag, " timeout_err"}, 32'(te), 32'(e_te));
        check({tag, " single_pulse"}, 32'(tail), 32'h0);
    endtask

    initial begin
        int seen_a;
        int seen_b;
        valid = 1'b1;
        a = 32'h4000_0000;
        #3;
        check("rst cs", 32'(bi_a.tgt_cs), 32'h0);
        check("rst ready", 32'(bi_a.cpu_ready), 32'h0);
        check("rst rdata", bi_a.cpu_rdata, 32'h0);
        check("rst decode_err", 32'(bi_a.decode_err), 32'h0);
        check("rst timeout_err", 32'(bi_a.timeout_err), 32'h0);
        valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        a = 32'h1234_5670;
        wdata = 32'h5555_aaaa;
        wstrb = 4'h6;
        #1;
        check("pass addr", bi_a.tgt_addr, 32'h1234_5670);
        check("pass wdata", bi_a.tgt_wdata, 32'h5555_aaaa);
        check("pass we", 32'(bi_a.tgt_we), 32'h6);
        check("pass idle cs", 32'(bi_a.tgt_cs), 32'h0);
        wstrb = '0;
        @(posedge clk);
        #1;

        xact("zero_wait", 32'h4000_0010, 4'h0, 1'b0, 0, 1'b0, 1, 4'h4, 1, 32'h1234_5678, 1'b0, 1'b0);
        xact("wait5", 32'h4000_0000, 4'h0, 1'b0, 5, 1'b0, 6, 4'h4, 6, 32'h1234_5678, 1'b0, 1'b0);

        lat = 1000;
        a = 32'h4000_0000;
        valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid pre cs", 32'(bi_a.tgt_cs), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid cs", 32'(bi_a.tgt_cs), 32'h0);
        check("rst_mid ready", 32'(bi_a.cpu_ready), 32'h0);
        check("rst_mid rdata", bi_a.cpu_rdata, 32'h0);
        check("rst_mid errs", 32'({bi_a.decode_err, bi_a.timeout_err}), 32'h0);
        @(posedge clk);
        #1;
        valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        xact("post_rst", 32'hc000_0100, 4'h0, 1'b0, 0, 1'b0, 1, 4'h8, 1, 32'hc3c3_3333, 1'b0, 1'b0);

        xact("timeout", 32'h4000_0000, 4'h0, 1'b0, 1000, 1'b1, 5, 4'h4, 5, 32'hdeadbeef, 1'b0, 1'b1);
        xact("unmapped", 32'h8000_0000, 4'h0, 1'b0, 0, 1'b0, 0, 4'h0, 1, 32'h0, 1'b1, 1'b0);
        xact("trap_unmapped", 32'h8000_0000, 4'h0, 1'b1, 0, 1'b0, 0, 4'h0, 1, TRAP, 1'b0, 1'b0);
        xact("trap_mapped", 32'h4000_0000, 4'h0, 1'b1, 0, 1'b0, 0, 4'h0, 1, TRAP, 1'b0, 1'b0);
        xact("priority", 32'h2000_0008, 4'h0, 1'b0, 0, 1'b0, 1, 4'h1, 1, 32'ha0a0_0000, 1'b0, 1'b0);
        xact("write_t3", 32'hc000_0100, 4'h3, 1'b0, 2, 1'b0, 3, 4'h8, 3, 32'h0, 1'b0, 1'b0);
        xact("write_unmap", 32'h8000_0004, 4'hf, 1'b0, 0, 1'b0, 0, 4'h0, 1, 32'h0, 1'b1, 1'b0);

        lat = 1000;
        a = 32'h4000_0000;
        valid = 1'b1;
        seen_a = 0;
        seen_b = 0;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            seen_a += int'(bi_a.cpu_ready);
            seen_b += int'(bi_b.cpu_ready);
        end
        check("abort ready_a", seen_a, 0);
        check("abort ready_b", seen_b, 0);
        xact("after_abort", 32'h4000_0000, 4'h0, 1'b0, 1, 1'b0, 2, 4'h4, 2, 32'h1234_5678, 1'b0, 1'b0);

`ifdef MEM_BUS_MUX_PROT_EN
        fw = 1'b1;
        xact("fw_blocked", 32'h0000_0100, 4'h0, 1'b0, 0, 1'b0, 0, 4'h0, 1, 32'h0, 1'b1, 1'b0);
        fw = 1'b0;
        xact("fw_allowed", 32'h0000_0100, 4'h0, 1'b0, 0, 1'b0, 1, 4'h1, 1, 32'ha0a0_0000, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
